// File: rtl/pipe_add_if.sv
// Streaming handshake bundle for pipe_add: operand side (in_*, a, b, cin, sub)
// and result side (out_*, sum) share one interface instance.
interface pipe_add_if #(
    parameter int N_BITS = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] b;
    logic              cin;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS:0]   sum;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/pipe_add.sv
// Pipelined adder/subtractor: the carry chain is cut into N_STAGES chunks, one
// register stage per chunk, with valid/ready flow control and bubble compression.
module pipe_add #(
    parameter int N_BITS   = 8,
    parameter int N_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_add_if.slave bus
);
    localparam int W    = N_BITS / N_STAGES;
    localparam int LAST = N_STAGES - 1;

    logic [N_BITS-1:0]   b_eff;
    logic                c0;
    logic [N_STAGES-1:0] v;
    logic [N_STAGES-1:0] e;
    logic [N_STAGES-1:0] pv;
    logic [N_STAGES-1:0] load;
    logic                chain;

    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.cin;

    // A stage may advance if it is empty or the stage after it advances.
    always_comb begin
        e       = '0;
        chain   = !v[LAST] || bus.out_ready;
        e[LAST] = chain;
        for (int k = LAST - 1; k >= 0; k--) begin
            chain = !v[k] || chain;
            e[k]  = chain;
        end
    end

    always_comb begin
        pv    = '0;
        pv[0] = bus.in_valid;
        for (int k = 1; k < N_STAGES; k++) begin
            pv[k] = v[k-1];
        end
    end

    assign load = e & pv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            v <= (v & ~e) | (pv & e);
        end
    end

    // Stage k keeps the finished low chunks plus the operand chunks still to be added.
    for (genvar k = 0; k < N_STAGES; k++) begin : stg
        localparam int PW = N_BITS - k * W;
        localparam int LO = (k + 1) * W;

        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        logic          pc;
        logic [W:0]    chunk;
        logic [LO-1:0] nres;
        logic [LO-1:0] res;
        logic          c;

        if (k == 0) begin : head
            assign pa   = bus.a;
            assign pb   = b_eff;
            assign pc   = c0;
            assign nres = chunk[W-1:0];
        end else begin : link
            assign pa   = stg[k-1].ops.oa;
            assign pb   = stg[k-1].ops.ob;
            assign pc   = stg[k-1].c;
            assign nres = {chunk[W-1:0], stg[k-1].res};
        end

        assign chunk = {1'b0, pa[W-1:0]} + {1'b0, pb[W-1:0]} + {{W{1'b0}}, pc};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res <= '0;
                c   <= 1'b0;
            end else if (load[k]) begin
                res <= nres;
                c   <= chunk[W];
            end
        end

        if (PW > W) begin : ops
            logic [PW-W-1:0] oa;
            logic [PW-W-1:0] ob;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    oa <= '0;
                    ob <= '0;
                end else if (load[k]) begin
                    oa <= pa[PW-1:W];
                    ob <= pb[PW-1:W];
                end
            end
        end
    end

    assign bus.in_ready  = e[0];
    assign bus.out_valid = v[LAST];
    assign bus.sum       = {stg[LAST].c, stg[LAST].res};
endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add: directed vectors on an 8x2 instance, then
// random traffic with backpressure on several width/stage configurations.
`define IDLE(IFC) \
    IFC.in_valid = 1'b0; IFC.a = '0; IFC.b = '0; \
    IFC.cin = 1'b0; IFC.sub = 1'b0; IFC.out_ready = 1'b1;

`define RUN_SWEEP(IFC, NB, NAME) \
    q.delete(); acc = 1'b0; sent = 0; nout = 0; \
    for (int cyc = 0; cyc < 400; cyc++) begin \
        @(negedge clk); \
        if (!IFC.in_valid || acc) begin \
            ra = {$urandom, $urandom}; \
            rb = {$urandom, $urandom}; \
            IFC.cin = 1'($urandom_range(0, 1)); \
            IFC.sub = ($urandom_range(0, 2) == 0); \
            if ($urandom_range(0, 3) == 0) begin \
                ra = '1; rb = '0; IFC.cin = 1'b1; IFC.sub = 1'b0; \
            end \
            IFC.a = ra[NB-1:0]; \
            IFC.b = rb[NB-1:0]; \
            IFC.in_valid = (cyc < 300) && ($urandom_range(0, 3) != 0); \
        end \
        IFC.out_ready = (cyc >= 300) || ($urandom_range(0, 3) != 0); \
        #1; \
        if (IFC.out_valid && IFC.out_ready) begin \
            got = 65'(IFC.sum); \
            nout++; \
            if (q.size() == 0) checkOutput({NAME, " spurious"}, got, 65'h1_dead_beef); \
            else checkOutput({NAME, " sum"}, got, q.pop_front()); \
        end \
        acc = IFC.in_valid && IFC.in_ready; \
        if (acc) begin \
            q.push_back(model(ra, rb, IFC.cin, IFC.sub, NB)); \
            sent++; \
        end \
    end \
    IFC.in_valid = 1'b0; \
    checkOutput({NAME, " count"}, 65'(nout), 65'(sent));

module tb_pipe_add;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] want;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          errors;
    int          checks;
    int          sent;
    int          nout;
    logic        acc;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [64:0] got;
    logic [64:0] bp_first;
    logic [64:0] q[$];
    vec_t        vecs[8];

    pipe_add_if #(.N_BITS(8))  bus ();
    pipe_add_if #(.N_BITS(8))  if81 ();
    pipe_add_if #(.N_BITS(8))  if88 ();
    pipe_add_if #(.N_BITS(32)) if324 ();
    pipe_add_if #(.N_BITS(64)) if648 ();

    pipe_add #(.N_BITS(8),  .N_STAGES(2)) dut      (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_add #(.N_BITS(8),  .N_STAGES(1)) dut_8x1  (.clk(clk), .rst_n(rst_n), .bus(if81));
    pipe_add #(.N_BITS(8),  .N_STAGES(8)) dut_8x8  (.clk(clk), .rst_n(rst_n), .bus(if88));
    pipe_add #(.N_BITS(32), .N_STAGES(4)) dut_32x4 (.clk(clk), .rst_n(rst_n), .bus(if324));
    pipe_add #(.N_BITS(64), .N_STAGES(8)) dut_64x8 (.clk(clk), .rst_n(rst_n), .bus(if648));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb, input int nb);
        logic [63:0] mask;
        logic [63:0] yy;
        mask = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
        yy   = sb ? (~y & mask) : (y & mask);
        return {1'b0, x & mask} + {1'b0, yy} + {64'd0, sb | ci};
    endfunction

    task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, want);
        end
    endtask

    // One isolated transaction with out_ready high; measures accept-to-valid latency.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input logic sub, input logic [8:0] want, input string name);
        int lat;
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput({name, " in_ready"}, 65'(bus.in_ready), 65'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            #1;
        end
        checkOutput({name, " latency"}, 65'(lat), 65'd2);
        checkOutput({name, " sum"}, 65'(bus.sum), 65'(want));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        acc    = 1'b0;
        sent   = 0;
        nout   = 0;
        ra     = '0;
        rb     = '0;
        `IDLE(bus)
        `IDLE(if81)
        `IDLE(if88)
        `IDLE(if324)
        `IDLE(if648)

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 9'h0FE};
        vecs[3] = '{8'h07, 8'h05, 1'b0, 1'b1, 9'h102};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 9'h001};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b1, 9'h100};
        vecs[6] = '{8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 1'b0, 9'h0FF};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset out_valid", 65'(bus.out_valid), 65'd0);
        checkOutput("reset sum", 65'(bus.sum), 65'd0);
        checkOutput("reset in_ready", 65'(bus.in_ready), 65'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].want,
                          $sformatf("vec%0d", i));
        end

        // Back-to-back stream: one result per cycle, in order.
        q.delete();
        nout = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc < 16) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                bus.a        = ra[7:0];
                bus.b        = rb[7:0];
                bus.cin      = 1'($urandom_range(0, 1));
                bus.sub      = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc < 16) checkOutput("stream in_ready", 65'(bus.in_ready), 65'd1);
            if (cyc >= 2 && cyc <= 17) checkOutput("stream out_valid", 65'(bus.out_valid), 65'd1);
            if (bus.out_valid) begin
                nout++;
                if (q.size() == 0) checkOutput("stream spurious", 65'(bus.sum), 65'h1_dead_beef);
                else checkOutput("stream sum", 65'(bus.sum), q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(ra, rb, bus.cin, bus.sub, 8));
        end
        checkOutput("stream count", 65'(nout), 65'd16);

        // Backpressure: three offers while out_ready is low for five cycles.
        q.delete();
        nout     = 0;
        sent     = 0;
        acc      = 1'b0;
        bp_first = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 5);
            if (!bus.in_valid || acc) begin
                if (sent < 3) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    bus.a        = ra[7:0];
                    bus.b        = rb[7:0];
                    bus.cin      = 1'b1;
                    bus.sub      = 1'b0;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checkOutput("stall in_ready", 65'(bus.in_ready), 65'd0);
                checkOutput("stall out_valid", 65'(bus.out_valid), 65'd1);
                checkOutput("stall sum", 65'(bus.sum), bp_first);
            end
            if (bus.out_valid && bus.out_ready) begin
                nout++;
                if (q.size() == 0) checkOutput("drain spurious", 65'(bus.sum), 65'h1_dead_beef);
                else checkOutput("drain sum", 65'(bus.sum), q.pop_front());
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                got = model(ra, rb, bus.cin, bus.sub, 8);
                if (sent == 0) bp_first = got;
                q.push_back(got);
                sent++;
            end
        end
        checkOutput("drain count", 65'(nout), 65'd3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Asynchronous reset with two transactions in flight.
        @(negedge clk);
        bus.a        = 8'h33;
        bus.b        = 8'h44;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.a = 8'h11;
        bus.b = 8'h22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checkOutput("pre-reset out_valid", 65'(bus.out_valid), 65'd1);
        checkOutput("pre-reset sum", 65'(bus.sum), 65'h077);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid-reset out_valid", 65'(bus.out_valid), 65'd0);
        checkOutput("mid-reset sum", 65'(bus.sum), 65'd0);
        checkOutput("mid-reset in_ready", 65'(bus.in_ready), 65'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 9'h030, "post-reset");

        `RUN_SWEEP(if81, 8, "sweep8x1")
        `RUN_SWEEP(if88, 8, "sweep8x8")
        `RUN_SWEEP(if324, 32, "sweep32x4")
        `RUN_SWEEP(if648, 64, "sweep64x8")

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
